multimedia_recorder: RTL



---
 rtl/multimedia_recorder_pkg.sv | 17 +
 rtl/multimedia_recorder_fifo.sv | 69 ++++++
 rtl/multimedia_recorder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/multimedia_recorder_pkg.sv
// rtl/multimedia_recorder_pkg.sv - shared types for the multimedia recorder
package definitions_multimedia;

   localparam int MM_WIDTH = 32;

   typedef struct packed {
      logic [MM_WIDTH-1:0] value;
      logic [MM_WIDTH-1:0] offset;
   } parameter_t;

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      RECORD = 3'b010,
      DONE   = 3'b100
   } recorder_state_t;

endpackage

// File: rtl/multimedia_recorder_fifo.sv
// rtl/multimedia_recorder_fifo.sv - first-word-fall-through circular FIFO of parameter_t entries
module multimedia_fifo
   import definitions_multimedia::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  parameter_t               push_data,
   input  logic                     pop,
   input  logic                     flush,
   output parameter_t               out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   parameter_t        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign out_data = empty ? '0 : mem_q[rd_ptr_q];

   // A push while full is dropped even if a pop frees a slot in the same cycle.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/multimedia_recorder.sv
// rtl/multimedia_recorder.sv - records player send/data events as {value, offset} entries
// Optional idle timeout enabled by MULTIMEDIA_RECORDER_TIMEOUT_EN.
module multimedia_recorder
   import definitions_multimedia::*;
#(
   parameter int WIDTH = MM_WIDTH,
   parameter int DEPTH = 16
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
   , parameter int TIMEOUT = 1000
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     kill_p,
   input  logic [WIDTH-1:0]         global_clock,
   input  logic                     send,
   input  logic [WIDTH-1:0]         data,
   output parameter_t               rd_entry,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
   output logic                     timed_out,
`endif
   output logic                     done
);

   recorder_state_t   state_q, state_d;
   logic [WIDTH-1:0]  ref_clock_q, ref_clock_d;
   logic              overflow_q, overflow_d;
   logic              push, flush, fifo_full, fifo_empty;
   parameter_t        push_data;

`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
   logic [31:0]       idle_cnt_q, idle_cnt_d;
   logic [WIDTH-1:0]  prev_gc_q;
   logic              timed_out_q, timed_out_d;
   assign timed_out = timed_out_q;
`endif

   // Modulo-2^WIDTH subtraction keeps deltas correct across global_clock wrap.
   assign push_data = '{value: data, offset: global_clock - ref_clock_q};

   always_comb begin
      state_d     = state_q;
      ref_clock_d = ref_clock_q;
      overflow_d  = overflow_q;
      push        = 1'b0;
      flush       = 1'b0;
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
      timed_out_d = timed_out_q;
      idle_cnt_d  = idle_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (kill_p) begin
               state_d = DONE;
            end else if (start) begin
               state_d     = RECORD;
               ref_clock_d = global_clock;
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
               idle_cnt_d  = '0;
`endif
            end
         end
         RECORD: begin
            if (kill_p) begin
               state_d = DONE;
            end else begin
               if (send) begin
                  push        = 1'b1;
                  ref_clock_d = global_clock;
               end
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
               if (send)                          idle_cnt_d = '0;
               else if (global_clock != prev_gc_q) idle_cnt_d = idle_cnt_q + 32'd1;
`endif
               if (stop) begin
                  state_d = DONE;
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
               end else if (!send && idle_cnt_q >= 32'(TIMEOUT)) begin
                  state_d     = DONE;
                  timed_out_d = 1'b1;
`endif
               end
            end
         end
         DONE: begin
            if (!kill_p && start) begin
               state_d     = RECORD;
               ref_clock_d = global_clock;
               flush       = 1'b1;
               overflow_d  = 1'b0;
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
               timed_out_d = 1'b0;
               idle_cnt_d  = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      if (push && fifo_full) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ref_clock_q <= '0;
         overflow_q  <= 1'b0;
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
         timed_out_q <= 1'b0;
         idle_cnt_q  <= '0;
         prev_gc_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ref_clock_q <= ref_clock_d;
         overflow_q  <= overflow_d;
`ifdef MULTIMEDIA_RECORDER_TIMEOUT_EN
         timed_out_q <= timed_out_d;
         idle_cnt_q  <= idle_cnt_d;
         prev_gc_q   <= global_clock;
`endif
      end
   end

   multimedia_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (rd_ready),
      .flush     (flush),
      .out_data  (rd_entry),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rd_valid = !fifo_empty;
   assign overflow = overflow_q;
   assign done     = (state_q == DONE);

endmodule
